// File: rtl/mutation_gene_packer.sv
// Packs up to three lane-valid genes per cycle, in lane order, into a FIFO and
// drains them as a single-gene valid/ready stream with occupancy, count and overflow status.
module mutation_gene_packer #(
   parameter int GENE_SZ = 64,
   parameter int ATTR_SZ = 8,
   parameter int DEPTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       setup,
   input  logic [2:0]                 in_valid,
   input  logic [GENE_SZ-1:0]         in_gene1,
   input  logic [GENE_SZ-1:0]         in_gene2,
   input  logic [GENE_SZ-1:0]         in_gene3,
   output logic                       in_ready,
   output logic [GENE_SZ-1:0]         out_gene,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [ATTR_SZ-1:0]         gene_count,
   output logic                       overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [GENE_SZ-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      free;
   logic [1:0]         n;
   logic [PW-1:0]      off2;
   logic [PW-1:0]      off3;
   logic               any_in;
   logic               push;
   logic               pop;

   // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
   assign n      = 2'(in_valid[0]) + 2'(in_valid[1]) + 2'(in_valid[2]);
   assign off2   = PW'(in_valid[0]);
   assign off3   = PW'(in_valid[0]) + PW'(in_valid[1]);

   assign free      = CW'(DEPTH) - cnt;
   assign in_ready  = (free >= CW'(3)) && !setup;
   assign any_in    = |in_valid;
   assign push      = any_in && in_ready;
   assign out_valid = (cnt != '0);
   assign pop       = out_valid && out_ready && !setup;
   assign out_gene  = out_valid ? mem[rd_ptr] : '0;
   assign occupancy = cnt;

   // NOTE: the storage array has no reset; entries are only read after being
   // written, and leaving it unreset lets it map onto plain RAM/flops without a reset net.
   always_ff @(posedge clk) begin
      if (push) begin
         if (in_valid[0]) mem[wr_ptr]        <= in_gene1;
         if (in_valid[1]) mem[wr_ptr + off2] <= in_gene2;
         if (in_valid[2]) mem[wr_ptr + off3] <= in_gene3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         gene_count   <= '0;
         overflow_err <= 1'b0;
      end else if (setup) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         gene_count   <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(n);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + (push ? CW'(n) : CW'(0)) - (pop ? CW'(1) : CW'(0));
         if (pop && (gene_count != '1)) gene_count <= gene_count + ATTR_SZ'(1);
         // Whole bundle is dropped when space is short; this flag is the only trace.
         if (any_in && !in_ready) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mutation_gene_packer.sv
// Scoreboard bench for mutation_gene_packer: a queue model tracks FIFO contents,
// count and overflow, and is compared against the DUT every falling edge.
module tb_mutation_gene_packer;

   localparam int GENE_SZ = 64;
   localparam int ATTR_SZ = 8;
   localparam int DEPTH   = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 setup = 1'b0;
   logic [2:0]           in_valid = '0;
   logic [GENE_SZ-1:0]   in_gene1 = '0;
   logic [GENE_SZ-1:0]   in_gene2 = '0;
   logic [GENE_SZ-1:0]   in_gene3 = '0;
   logic                 in_ready;
   logic [GENE_SZ-1:0]   out_gene;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [$clog2(DEPTH):0] occupancy;
   logic [ATTR_SZ-1:0]   gene_count;
   logic                 overflow_err;

   int checks = 0;
   int failures = 0;

   logic [GENE_SZ-1:0] exp_q[$];
   int                 m_gc = 0;
   bit                 m_ovf = 1'b0;

   mutation_gene_packer #(.GENE_SZ(GENE_SZ), .ATTR_SZ(ATTR_SZ), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .setup(setup), .in_valid(in_valid),
      .in_gene1(in_gene1), .in_gene2(in_gene2), .in_gene3(in_gene3),
      .in_ready(in_ready), .out_gene(out_gene), .out_valid(out_valid),
      .out_ready(out_ready), .occupancy(occupancy), .gene_count(gene_count),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] v, input logic [63:0] g1, input logic [63:0] g2,
                        input logic [63:0] g3, input logic r);
      in_valid  = v;
      in_gene1  = g1;
      in_gene2  = g2;
      in_gene3  = g3;
      out_ready = r;
      step();
   endtask

   task automatic idle(input logic r, input int cycles);
      for (int i = 0; i < cycles; i++) drive(3'b000, '0, '0, '0, r);
   endtask

   // Model: compare outputs mid-cycle, then apply the edge the DUT is about to take.
   always @(negedge clk) begin : monitor
      logic m_ready;
      if (rst_n) begin
         m_ready = ((DEPTH - exp_q.size()) >= 3) && !setup;
         check("occupancy", 64'(occupancy), 64'(exp_q.size()));
         check("in_ready", 64'(in_ready), 64'(m_ready));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         check("out_gene", out_gene, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
         check("gene_count", 64'(gene_count), 64'(m_gc));
         check("overflow_err", 64'(overflow_err), 64'(m_ovf));
         if (setup) begin
            exp_q.delete();
            m_gc  = 0;
            m_ovf = 1'b0;
         end else begin
            if ((exp_q.size() != 0) && out_ready) begin
               void'(exp_q.pop_front());
               if (m_gc < (1 << ATTR_SZ) - 1) m_gc++;
            end
            if (in_valid != 3'b000) begin
               if (m_ready) begin
                  if (in_valid[0]) exp_q.push_back(in_gene1);
                  if (in_valid[1]) exp_q.push_back(in_gene2);
                  if (in_valid[2]) exp_q.push_back(in_gene3);
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_gene", out_gene, 64'h0);
      check("rst_occupancy", 64'(occupancy), 64'h0);
      check("rst_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single gene through with zero-wait head
      drive(3'b001, 64'hA1, 64'hDEAD, 64'hBEEF, 1'b1);
      check("t1_valid", 64'(out_valid), 64'h1);
      check("t1_gene", out_gene, 64'hA1);
      drive(3'b000, '0, '0, '0, 1'b1);
      check("t1_count", 64'(gene_count), 64'h1);
      check("t1_empty", 64'(out_valid), 64'h0);

      // Full bundle held, then drained in lane order
      drive(3'b111, 64'h11, 64'h22, 64'h33, 1'b0);
      check("t2_occ", 64'(occupancy), 64'h3);
      idle(1'b1, 4);

      // Sparse bundle packs gene1 then gene3
      drive(3'b101, 64'h5, 64'h6, 64'h7, 1'b0);
      check("t3_occ", 64'(occupancy), 64'h2);
      check("t3_head", out_gene, 64'h5);
      idle(1'b1, 3);

      // Overflow: third bundle dropped whole
      drive(3'b111, 64'h101, 64'h102, 64'h103, 1'b0);
      drive(3'b111, 64'h104, 64'h105, 64'h106, 1'b0);
      check("t4_ready_low", 64'(in_ready), 64'h0);
      drive(3'b111, 64'h107, 64'h108, 64'h109, 1'b0);
      check("t4_ovf", 64'(overflow_err), 64'h1);
      check("t4_occ", 64'(occupancy), 64'h6);
      idle(1'b1, 7);

      // Wrap with concurrent push/pop from a clean start
      setup = 1'b1;
      drive(3'b000, '0, '0, '0, 1'b1);
      setup = 1'b0;
      drive(3'b111, 64'h201, 64'h202, 64'h203, 1'b1);
      drive(3'b111, 64'h204, 64'h205, 64'h206, 1'b1);
      drive(3'b001, 64'h207, 64'h0, 64'h0, 1'b1);
      check("t5_occ_pre", 64'(occupancy), 64'h5);
      drive(3'b111, 64'h208, 64'h209, 64'h20A, 1'b1);
      check("t5_occ_post", 64'(occupancy), 64'h7);
      idle(1'b1, 9);
      check("t5_drained", 64'(occupancy), 64'h0);

      // Build 5 queued, overflow set, gene_count 9, then setup
      setup = 1'b1;
      drive(3'b000, '0, '0, '0, 1'b0);
      setup = 1'b0;
      drive(3'b111, 64'h301, 64'h302, 64'h303, 1'b1);
      drive(3'b111, 64'h304, 64'h305, 64'h306, 1'b1);
      drive(3'b111, 64'h307, 64'h308, 64'h309, 1'b1);
      drive(3'b111, 64'h30A, 64'h30B, 64'h30C, 1'b1);
      idle(1'b1, 4);
      drive(3'b111, 64'h30D, 64'h30E, 64'h30F, 1'b1);
      drive(3'b011, 64'h310, 64'h311, 64'h0, 1'b1);
      in_valid = 3'b000;
      out_ready = 1'b0;
      check("t6_occ", 64'(occupancy), 64'h5);
      check("t6_ovf", 64'(overflow_err), 64'h1);
      check("t6_gc", 64'(gene_count), 64'h9);
      setup = 1'b1;
      drive(3'b111, 64'h401, 64'h402, 64'h403, 1'b1);
      setup = 1'b0;
      check("t6_clr_occ", 64'(occupancy), 64'h0);
      check("t6_clr_valid", 64'(out_valid), 64'h0);
      check("t6_clr_ovf", 64'(overflow_err), 64'h0);
      check("t6_clr_gc", 64'(gene_count), 64'h0);

      // Asynchronous reset in the middle of a drain
      drive(3'b111, 64'h501, 64'h502, 64'h503, 1'b0);
      drive(3'b000, '0, '0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t7_valid", 64'(out_valid), 64'h0);
      check("t7_occ", 64'(occupancy), 64'h0);
      check("t7_gc", 64'(gene_count), 64'h0);
      exp_q.delete();
      m_gc  = 0;
      m_ovf = 1'b0;
      idle(1'b0, 2);
      rst_n = 1'b1;
      drive(3'b010, 64'h0, 64'h601, 64'h0, 1'b1);
      check("t7_after", out_gene, 64'h601);
      idle(1'b1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
